// File: rtl/bus_source_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_source_sequencer
// Description : Converts a 5-bit bus source code into a one-hot drive enable.
//               Each drive is held for HOLD_CYCLES. Idle gap cycles are placed
//               between different sources.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_source_sequencer #(
    parameter int NUM_SOURCES = 24,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [4:0]  sel_code,
    input  logic        sel_valid,
    output logic        sel_ready,
    output logic [31:0] drive_en,
    output logic        drive_last,
    output logic        busy,
    output logic        bad_code
);

    localparam int c_MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [5:0]         c_NUM_SRC   = 6'(NUM_SOURCES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_code;
    logic [31:0]        r_drive_en;
    logic               r_drive_last;
    logic               r_busy;
    logic               r_bad_code;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [4:0]         w_code_nxt;
    logic               w_bad_nxt;
    logic               w_final;
    logic               w_legal;
    logic               w_accept;

    // Ready depends only on state and counter so the requester cannot loop back.
    assign w_final   = (r_cnt == '0);
    assign sel_ready = (r_state == c_IDLE) || ((r_state == c_DRIVE) && w_final);
    assign w_legal   = ({1'b0, sel_code} < c_NUM_SRC);
    assign w_accept  = sel_valid && sel_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_bad_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt = c_DRIVE;
                        w_cnt_nxt   = c_HOLD_LOAD;
                        w_code_nxt  = sel_code;
                    end else begin
                        w_bad_nxt = 1'b1;
                    end
                end
            end
            c_DRIVE: begin
                if (!w_final) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = c_IDLE;
                        w_bad_nxt   = 1'b1;
                    end else if (sel_code == r_code) begin
                        w_cnt_nxt = c_HOLD_LOAD;
                    end else begin
                        // The held code doubles as the pending code while in GAP.
                        w_state_nxt = c_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                        w_code_nxt  = sel_code;
                    end
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_GAP: begin
                if (!w_final) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_state_nxt = c_DRIVE;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_code       <= '0;
            r_drive_en   <= '0;
            r_drive_last <= 1'b0;
            r_busy       <= 1'b0;
            r_bad_code   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_code       <= w_code_nxt;
            r_drive_en   <= (w_state_nxt == c_DRIVE) ? (32'd1 << w_code_nxt) : 32'd0;
            r_drive_last <= (w_state_nxt == c_DRIVE) && (w_cnt_nxt == '0);
            r_busy       <= (w_state_nxt != c_IDLE);
            r_bad_code   <= w_bad_nxt;
        end
    end

    assign drive_en   = r_drive_en;
    assign drive_last = r_drive_last;
    assign busy       = r_busy;
    assign bad_code   = r_bad_code;

endmodule
`default_nettype wire
